// File: rtl/lfsr_checker_if.sv
// Serial PRBS stream bus between a bit source and lfsr_checker.
// The source drives the stream and controls; the checker returns lock and error status.
interface lfsr_checker_if;
  logic        enable;
  logic        i_Bit_DV;
  logic        i_Bit;
  logic        i_Clear;
  logic        o_Locked;
  logic        o_Err;
  logic [31:0] o_Err_Count;

  modport master (
    output enable, i_Bit_DV, i_Bit, i_Clear,
    input  o_Locked, o_Err, o_Err_Count
  );

  modport slave (
    input  enable, i_Bit_DV, i_Bit, i_Clear,
    output o_Locked, o_Err, o_Err_Count
  );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the XNOR Fibonacci LFSR bit stream: fills a shadow register,
// verifies predictions until lock, then flywheels and counts bit errors per monitoring window.
module lfsr_checker #(
  parameter int unsigned NUM_BITS    = 32,
  parameter int unsigned LOCK_COUNT  = 64,
  parameter int unsigned WINDOW      = 1024,
  parameter int unsigned UNLOCK_ERRS = 16
) (
  input logic           clk,
  input logic           rst_n,
  lfsr_checker_if.slave bus
);

  function automatic logic [63:0] tap(input int unsigned t);
    return 64'd1 << (t - 1);
  endfunction

  // Bit i of the mask selects shadow position i+1 (position 1 = newest bit).
  function automatic logic [63:0] tap_mask(input int unsigned n);
    logic [63:0] m;
    m = '0;
    case (n)
      3:  m = tap(3) | tap(2);
      4:  m = tap(4) | tap(3);
      5:  m = tap(5) | tap(3);
      6:  m = tap(6) | tap(5);
      7:  m = tap(7) | tap(6);
      8:  m = tap(8) | tap(6) | tap(5) | tap(4);
      9:  m = tap(9) | tap(5);
      10: m = tap(10) | tap(7);
      11: m = tap(11) | tap(9);
      12: m = tap(12) | tap(6) | tap(4) | tap(1);
      13: m = tap(13) | tap(4) | tap(3) | tap(1);
      14: m = tap(14) | tap(5) | tap(3) | tap(1);
      15: m = tap(15) | tap(14);
      16: m = tap(16) | tap(15) | tap(13) | tap(4);
      17: m = tap(17) | tap(14);
      18: m = tap(18) | tap(11);
      19: m = tap(19) | tap(6) | tap(2) | tap(1);
      20: m = tap(20) | tap(17);
      21: m = tap(21) | tap(19);
      22: m = tap(22) | tap(21);
      23: m = tap(23) | tap(18);
      24: m = tap(24) | tap(23) | tap(22) | tap(17);
      25: m = tap(25) | tap(22);
      26: m = tap(26) | tap(6) | tap(2) | tap(1);
      27: m = tap(27) | tap(5) | tap(2) | tap(1);
      28: m = tap(28) | tap(25);
      29: m = tap(29) | tap(27);
      30: m = tap(30) | tap(6) | tap(4) | tap(1);
      31: m = tap(31) | tap(28);
      32: m = tap(32) | tap(22) | tap(2) | tap(1);
      64: m = tap(64) | tap(63) | tap(61) | tap(60);
      default: m = '0;
    endcase
    return m;
  endfunction

  if (!((NUM_BITS >= 3 && NUM_BITS <= 32) || NUM_BITS == 64)) begin : g_bad_num_bits
    $error("lfsr_checker: NUM_BITS must be 3..32 or 64");
  end
  if (LOCK_COUNT < 1 || LOCK_COUNT > 65535) begin : g_bad_lock_count
    $error("lfsr_checker: LOCK_COUNT must be 1..65535");
  end
  if (WINDOW < 2 || WINDOW > 65536) begin : g_bad_window
    $error("lfsr_checker: WINDOW must be 2..65536");
  end
  if (UNLOCK_ERRS < 1 || UNLOCK_ERRS > WINDOW) begin : g_bad_unlock_errs
    $error("lfsr_checker: UNLOCK_ERRS must be 1..WINDOW");
  end

  localparam logic [63:0]         TapMask    = tap_mask(NUM_BITS);
  localparam logic [NUM_BITS-1:0] Taps       = TapMask[NUM_BITS-1:0];
  localparam logic [15:0]         FillLen    = 16'(NUM_BITS);
  localparam logic [15:0]         LockLen    = 16'(LOCK_COUNT);
  localparam logic [16:0]         WindowLen  = 17'(WINDOW);
  localparam logic [16:0]         UnlockErrs = 17'(UNLOCK_ERRS);

  typedef enum logic [1:0] {StFill, StVerify, StLocked} state_e;

  state_e              state_q;
  logic [NUM_BITS-1:0] sr_q;
  logic [15:0]         cnt_q;
  logic [16:0]         wcnt_q;
  logic [16:0]         ecnt_q;
  logic                locked_q;
  logic                err_q;
  logic [31:0]         err_count_q;
  logic [31:0]         err_count_d;

  logic                accept;
  logic                pred;
  logic                mismatch;
  logic                count_err;
  logic [NUM_BITS-1:0] sr_rx;
  logic [NUM_BITS-1:0] sr_fly;
  logic [15:0]         cnt_inc;
  logic [16:0]         wcnt_inc;
  logic [16:0]         ecnt_inc;

  assign accept    = bus.enable & bus.i_Bit_DV;
  // Every tap list has an even length, so the XNOR chain reduces to one inverted parity.
  assign pred      = ~^(sr_q & Taps);
  assign mismatch  = bus.i_Bit != pred;
  assign count_err = accept && (state_q == StLocked) && mismatch;
  assign sr_rx     = {sr_q[NUM_BITS-2:0], bus.i_Bit};
  assign sr_fly    = {sr_q[NUM_BITS-2:0], pred};
  assign cnt_inc   = cnt_q + 16'd1;
  assign wcnt_inc  = wcnt_q + 17'd1;
  assign ecnt_inc  = ecnt_q + 17'd1;

  // Clear takes effect before a same-cycle increment.
  always_comb begin
    err_count_d = err_count_q;
    if (bus.enable && bus.i_Clear) begin
      err_count_d = '0;
    end
    if (count_err && err_count_d != '1) begin
      err_count_d = err_count_d + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StFill;
      sr_q        <= '0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      ecnt_q      <= '0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_q       <= count_err;
      err_count_q <= err_count_d;
      if (accept) begin
        unique case (state_q)
          StFill: begin
            sr_q <= sr_rx;
            if (cnt_inc == FillLen) begin
              cnt_q <= '0;
              // An all-ones shadow is the XNOR lock-up state; keep filling.
              if (!(&sr_rx)) begin
                state_q <= StVerify;
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          StVerify: begin
            sr_q <= sr_rx;
            if (!mismatch) begin
              if (cnt_inc == LockLen) begin
                state_q  <= StLocked;
                locked_q <= 1'b1;
                cnt_q    <= '0;
                wcnt_q   <= '0;
                ecnt_q   <= '0;
              end else begin
                cnt_q <= cnt_inc;
              end
            end else begin
              // The mismatching bit is already in the shadow as the first fill bit.
              state_q <= StFill;
              cnt_q   <= 16'd1;
            end
          end
          StLocked: begin
            // Flywheel on the prediction so a single line error is counted once.
            sr_q <= sr_fly;
            if (mismatch && ecnt_inc == UnlockErrs) begin
              state_q  <= StFill;
              locked_q <= 1'b0;
              cnt_q    <= '0;
            end else if (wcnt_inc == WindowLen) begin
              wcnt_q <= '0;
              ecnt_q <= '0;
            end else begin
              wcnt_q <= wcnt_inc;
              if (mismatch) begin
                ecnt_q <= ecnt_inc;
              end
            end
          end
          default: state_q <= StFill;
        endcase
      end
    end
  end

  assign bus.o_Locked    = locked_q;
  assign bus.o_Err       = err_q & bus.enable;
  assign bus.o_Err_Count = err_count_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: four instances with different lengths, expected lock,
// unlock, error and status events queued by the stimulus and matched by a negedge monitor.
module tb_lfsr_checker;

  logic   clk = 1'b0;
  logic   rst_n;
  longint cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lfsr_checker_if bus0 ();
  lfsr_checker_if bus1 ();
  lfsr_checker_if bus2 ();
  lfsr_checker_if bus3 ();

  logic [3:0]  en_v;
  logic [3:0]  clr_v;
  logic        dv_s;
  logic        bit_s;
  logic [3:0]  lk;
  logic [3:0]  er;
  logic [31:0] ec [4];

  assign bus0.enable = en_v[0];  assign bus0.i_Clear = clr_v[0];
  assign bus1.enable = en_v[1];  assign bus1.i_Clear = clr_v[1];
  assign bus2.enable = en_v[2];  assign bus2.i_Clear = clr_v[2];
  assign bus3.enable = en_v[3];  assign bus3.i_Clear = clr_v[3];
  assign bus0.i_Bit_DV = dv_s;   assign bus0.i_Bit = bit_s;
  assign bus1.i_Bit_DV = dv_s;   assign bus1.i_Bit = bit_s;
  assign bus2.i_Bit_DV = dv_s;   assign bus2.i_Bit = bit_s;
  assign bus3.i_Bit_DV = dv_s;   assign bus3.i_Bit = bit_s;
  assign lk = {bus3.o_Locked, bus2.o_Locked, bus1.o_Locked, bus0.o_Locked};
  assign er = {bus3.o_Err, bus2.o_Err, bus1.o_Err, bus0.o_Err};
  assign ec[0] = bus0.o_Err_Count;
  assign ec[1] = bus1.o_Err_Count;
  assign ec[2] = bus2.o_Err_Count;
  assign ec[3] = bus3.o_Err_Count;

  lfsr_checker #(.NUM_BITS(8), .LOCK_COUNT(16), .WINDOW(64), .UNLOCK_ERRS(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
  lfsr_checker #(.NUM_BITS(32)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  lfsr_checker #(.NUM_BITS(16)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  lfsr_checker #(.NUM_BITS(64), .LOCK_COUNT(16)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

  typedef enum int {KRise, KFall, KErr, KSnap} kind_e;
  typedef struct {
    int          dut;
    kind_e       kind;
    longint      cyc;
    logic        lock;
    logic [31:0] count;
  } ev_t;

  ev_t         exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  longint      stamp;
  logic [63:0] g [4];
  logic        exp_lk [4];
  int          nbits [4] = '{8, 32, 16, 64};

  // Reference generator: next stream bit from the 1-based tap lists.
  function automatic logic gen_next(input int n, input logic [63:0] r);
    case (n)
      8:       return ~(r[7] ^ r[5] ^ r[4] ^ r[3]);
      16:      return ~(r[15] ^ r[14] ^ r[12] ^ r[3]);
      32:      return ~(r[31] ^ r[21] ^ r[1] ^ r[0]);
      default: return ~(r[63] ^ r[62] ^ r[60] ^ r[59]);
    endcase
  endfunction

  task automatic push(input int d, input kind_e k, input logic lock, input logic [31:0] c);
    ev_t e;
    e.dut = d; e.kind = k; e.cyc = stamp; e.lock = lock; e.count = c;
    exp_q.push_back(e);
    if (k == KRise) exp_lk[d] = 1'b1;
    if (k == KFall) exp_lk[d] = 1'b0;
  endtask

  // Inputs change 1 time unit after a rising edge and are sampled at the next one.
  task automatic drive(input int d, input logic en, input logic dv, input logic b,
                       input logic clr);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en_v = '0; clr_v = '0;
    en_v[d] = en; clr_v[d] = clr;
    dv_s = dv; bit_s = b;
    stamp = cyc + 1;
  endtask

  task automatic send(input int d, input logic inj, input logic clr);
    logic b;
    b = gen_next(nbits[d], g[d]);
    g[d] = {g[d][62:0], b};
    drive(d, 1'b1, 1'b1, b ^ inj, clr);
  endtask

  task automatic send_n(input int d, input int n);
    repeat (n) send(d, 1'b0, 1'b0);
  endtask

  task automatic snap(input int d, input logic lock, input logic [31:0] c);
    drive(d, 1'b1, 1'b0, 1'b0, 1'b0);
    push(d, KSnap, lock, c);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    en_v = '0; clr_v = '0; dv_s = 1'b0;
    stamp = cyc + 1;
    for (int d = 0; d < 4; d++) if (exp_lk[d]) push(d, KFall, 1'b0, 32'd0);
  endtask

  task automatic check_ev(input int d, input kind_e k);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected: got dut%0d %s cyc %0d count %0d, required no event",
               d, k.name(), cyc, ec[d]);
    end else begin
      e = exp_q.pop_front();
      if (e.dut != d || e.kind != k || e.cyc != cyc || e.count != ec[d]) begin
        n_bad++;
        $display("FAIL event: got dut%0d %s cyc %0d count %0d, required dut%0d %s cyc %0d count %0d",
                 d, k.name(), cyc, ec[d], e.dut, e.kind.name(), e.cyc, e.count);
      end
    end
  endtask

  initial begin : monitor
    logic [3:0] prev;
    ev_t        e;
    prev = '0;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL missed: got nothing, required dut%0d %s at cyc %0d count %0d",
                 e.dut, e.kind.name(), e.cyc, e.count);
      end
      for (int d = 0; d < 4; d++) begin
        if (er[d]) check_ev(d, KErr);
        if (lk[d] != prev[d]) check_ev(d, lk[d] ? KRise : KFall);
        prev[d] = lk[d];
      end
      while (exp_q.size() > 0 && exp_q[0].kind == KSnap && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (lk[e.dut] !== e.lock || ec[e.dut] !== e.count) begin
          n_bad++;
          $display("FAIL status dut%0d cyc %0d: got locked %0b count %0d, required locked %0b count %0d",
                   e.dut, cyc, lk[e.dut], ec[e.dut], e.lock, e.count);
        end
      end
    end
  end

  initial begin : stimulus
    int   errs;
    int   acc;
    logic phase;
    logic gap_done;
    rst_n = 1'b0;
    en_v = '0; clr_v = '0; dv_s = 1'b0; bit_s = 1'b0;
    for (int d = 0; d < 4; d++) begin
      exp_lk[d] = 1'b0;
      g[d] = '0;
    end
    repeat (2) @(posedge clk);
    for (int d = 0; d < 4; d++) snap(d, 1'b0, 32'd0);

    // NUM_BITS=8, LOCK_COUNT=16: lock after bit 24, then a clean run to 1000 bits.
    g[0] = 64'h1;
    for (int i = 1; i <= 1000; i++) begin
      send(0, 1'b0, 1'b0);
      if (i == 24) push(0, KRise, 1'b1, 32'd0);
    end
    snap(0, 1'b1, 32'd0);

    // Four errors inside one 64-bit window: the fourth drops lock and is still counted.
    errs = 0;
    for (int i = 1; i <= 16; i++) begin
      send(0, (i % 5) == 1, 1'b0);
      if ((i % 5) == 1) begin
        errs++;
        push(0, KErr, 1'b1, errs);
        if (errs == 4) push(0, KFall, 1'b0, 32'd4);
      end
    end
    for (int i = 1; i <= 24; i++) begin
      send(0, 1'b0, 1'b0);
      if (i == 24) push(0, KRise, 1'b1, 32'd4);
    end

    // Three errors per window, one on the window's last bit, never unlock.
    for (int w = 0; w < 5; w++) begin
      for (int p = 1; p <= 64; p++) begin
        send(0, p == 1 || p == 33 || p == 64, 1'b0);
        if (p == 1 || p == 33 || p == 64) begin
          errs++;
          push(0, KErr, 1'b1, errs);
        end
      end
    end
    snap(0, 1'b1, 32'd19);

    // Clear alone, then clear together with an error, then climb to seven.
    send(0, 1'b0, 1'b1);
    snap(0, 1'b1, 32'd0);
    send(0, 1'b1, 1'b1);
    push(0, KErr, 1'b1, 32'd1);
    for (int k = 2; k <= 7; k++) begin
      send_n(0, 39);
      send(0, 1'b1, 1'b0);
      push(0, KErr, 1'b1, k);
    end
    snap(0, 1'b1, 32'd7);

    // One-cycle reset mid-lock, then relock with DV toggling and a 5-cycle enable gap.
    pulse_reset();
    acc = 0;
    phase = 1'b1;
    gap_done = 1'b0;
    while (acc < 24) begin
      if (acc == 10 && !gap_done) begin
        repeat (5) drive(0, 1'b0, 1'b1, 1'($urandom()), 1'b0);
        gap_done = 1'b1;
      end else if (phase) begin
        send(0, 1'b0, 1'b0);
        acc++;
        if (acc == 24) push(0, KRise, 1'b1, 32'd0);
        phase = 1'b0;
      end else begin
        drive(0, 1'b1, 1'b0, 1'($urandom()), 1'b0);
        phase = 1'b1;
      end
    end

    // NUM_BITS=16: all-ones stays in fill, a random stream never locks.
    repeat (200) drive(2, 1'b1, 1'b1, 1'b1, 1'b0);
    snap(2, 1'b0, 32'd0);
    repeat (10000) drive(2, 1'b1, 1'b1, 1'($urandom()), 1'b0);
    snap(2, 1'b0, 32'd0);

    // NUM_BITS=32: a single inverted bit is one error and lock holds.
    g[1] = 64'h1;
    for (int i = 1; i <= 96; i++) begin
      send(1, 1'b0, 1'b0);
      if (i == 96) push(1, KRise, 1'b1, 32'd0);
    end
    send_n(1, 20);
    send(1, 1'b1, 1'b0);
    push(1, KErr, 1'b1, 32'd1);
    send_n(1, 100);
    snap(1, 1'b1, 32'd1);

    // NUM_BITS=64: lock, seven errors, reset, relock after 64+16 bits.
    g[3] = 64'h1;
    for (int i = 1; i <= 80; i++) begin
      send(3, 1'b0, 1'b0);
      if (i == 80) push(3, KRise, 1'b1, 32'd0);
    end
    for (int k = 1; k <= 7; k++) begin
      send_n(3, 39);
      send(3, 1'b1, 1'b0);
      push(3, KErr, 1'b1, k);
    end
    snap(3, 1'b1, 32'd7);
    pulse_reset();
    for (int i = 1; i <= 80; i++) begin
      send(3, 1'b0, 1'b0);
      if (i == 80) push(3, KRise, 1'b1, 32'd0);
    end
    snap(3, 1'b1, 32'd0);

    repeat (3) drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL leftover: got %0d expected events unmatched, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
